modmul_seq_12b: RTL and testbench

MODMUL_SEQ_12B -- requirements
Module: modmul_seq_12b

---
 rtl/ntt_pkg.sv | 13 +
 rtl/mod_cond_sub.sv | 20 ++
 rtl/modmul_seq_12b.sv | 129 ++++++++++++
 tb/tb_modmul_seq_12b.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared defaults and FSM encoding for the sequential modular multiplier.
package ntt_pkg;

  localparam int DEF_WIDTH = 12;
  localparam int DEF_Q     = 3329;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mod_cond_sub.sv
// Conditional subtraction: folds a value below 2Q into the range 0..Q-1.
module mod_cond_sub
  import ntt_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int Q     = DEF_Q
) (
  input  logic [WIDTH:0]   i_x,
  output logic [WIDTH-1:0] o_y
);

  localparam logic [WIDTH:0] QX = (WIDTH+1)'(Q);

  logic w_ge;

  assign w_ge = (i_x >= QX);
  // The result is below Q < 2^WIDTH, so the top bit of either branch is zero.
  assign o_y  = WIDTH'(w_ge ? (i_x - QX) : i_x);

endmodule

// File: rtl/modmul_seq_12b.sv
// Bit-serial (MSB first) modular multiplier: res = (a*b) mod Q, one
// multiplier bit per cycle, valid/ready handshake on both sides.
module modmul_seq_12b
  import ntt_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int Q     = DEF_Q
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] res_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_a_red;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;

  state_e           w_state_nxt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_a_red_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic [WIDTH-1:0] w_a_red;   // a_i folded below Q
  logic [WIDTH-1:0] w_d;       // 2*acc mod Q
  logic [WIDTH:0]   w_sum;     // d + a_red, below 2Q
  logic [WIDTH-1:0] w_add;     // (d + a_red) mod Q

  // Any WIDTH-bit input is below 2Q, so a single subtraction suffices.
  mod_cond_sub #(.WIDTH(WIDTH), .Q(Q)) u_red_a (
    .i_x ({1'b0, a_i}),
    .o_y (w_a_red)
  );

  mod_cond_sub #(.WIDTH(WIDTH), .Q(Q)) u_dbl (
    .i_x ({r_acc, 1'b0}),
    .o_y (w_d)
  );

  assign w_sum = {1'b0, w_d} + {1'b0, r_a_red};

  mod_cond_sub #(.WIDTH(WIDTH), .Q(Q)) u_add (
    .i_x (w_sum),
    .o_y (w_add)
  );

  // Next-state and datapath update; everything holds unless a case below moves it.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_a_red_nxt = r_a_red;
    w_b_nxt     = r_b;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (in_valid_i) begin
          w_a_red_nxt = w_a_red;
          w_b_nxt     = b_i;
          w_acc_nxt   = {WIDTH{1'b0}};
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = ST_MUL;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (r_b[r_cnt]) begin
          w_acc_nxt = w_add;
        end else begin
          w_acc_nxt = w_d;
        end
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; handshake flags are registered decodes of the next state.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state     <= ST_IDLE;
      r_acc       <= {WIDTH{1'b0}};
      r_a_red     <= {WIDTH{1'b0}};
      r_b         <= {WIDTH{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_a_red     <= w_a_red_nxt;
      r_b         <= w_b_nxt;
      r_cnt       <= w_cnt_nxt;
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_DONE);
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign res_o       = r_acc;

endmodule

// File: tb/tb_modmul_seq_12b.sv
// Directed and random-sweep bench for modmul_seq_12b (WIDTH=12, Q=3329).
module tb_modmul_seq_12b;

  localparam int W = 12;
  localparam int QM = 3329;
  localparam int SWEEP_N = 2500;

  logic          clk;
  logic          reset_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [W-1:0]  a_i;
  logic [W-1:0]  b_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [W-1:0]  res_o;

  int errors;
  int checks;

  modmul_seq_12b #(.WIDTH(W), .Q(QM)) dut (
    .clock_i     (clk),
    .reset_i     (reset_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .res_o       (res_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One edge, then settle to the falling edge where outputs are sampled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Start one operation from IDLE (called at a negedge). Garbage operands are
  // held on the inputs during MUL to show they are ignored outside IDLE.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    check("idle_ready", {31'd0, in_ready_o}, 32'd1);
    in_valid_i = 1'b1;
    a_i = a;
    b_i = b;
    step();
    a_i = ~a;
    b_i = ~b;
  endtask

  // Count edges until out_valid_o; bounded so a stuck DUT still finishes.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid_o && lat < 40) begin
      check("busy_not_ready", {31'd0, in_ready_o}, 32'd0);
      step();
      lat++;
    end
    in_valid_i = 1'b0;
  endtask

  // Hold the result for 'stall' cycles, then hand it off and expect IDLE.
  task automatic finish_op(input int stall, input logic [W-1:0] exp_res);
    out_ready_i = 1'b0;
    for (int s = 0; s < stall; s++) begin
      step();
      check("stall_valid", {31'd0, out_valid_o}, 32'd1);
      check("stall_res", {20'd0, res_o}, {20'd0, exp_res});
      check("stall_not_ready", {31'd0, in_ready_o}, 32'd0);
    end
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    check("post_hs_ready", {31'd0, in_ready_o}, 32'd1);
    check("post_hs_valid", {31'd0, out_valid_o}, 32'd0);
  endtask

  task automatic full_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_res, input int stall);
    int lat;
    start_op(a, b);
    wait_done(lat);
    check({tag, "_latency"}, lat, 32'd12);
    check({tag, "_res"}, {20'd0, res_o}, {20'd0, exp_res});
    finish_op(stall, exp_res);
  endtask

  initial begin
    int lat;
    int seen_valid;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int exp_i;

    errors = 0;
    checks = 0;
    reset_i = 1'b1;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    a_i = '0;
    b_i = '0;

    @(negedge clk);
    step();
    step();
    check("rst_ready", {31'd0, in_ready_o}, 32'd1);
    check("rst_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst_res", {20'd0, res_o}, 32'd0);
    reset_i = 1'b0;

    // IDLE with no request: nothing moves.
    step();
    step();
    check("idle_hold_ready", {31'd0, in_ready_o}, 32'd1);
    check("idle_hold_res", {20'd0, res_o}, 32'd0);

    // Basic product, exact latency, ignored inputs during MUL.
    full_op("17x17", 12'd17, 12'd17, 12'd289, 0);
    // (Q-1)^2 = 1 mod Q; 2*1665 = 3330 = 1 mod Q.
    full_op("3328x3328", 12'd3328, 12'd3328, 12'd1, 1);
    full_op("2x1665", 12'd2, 12'd1665, 12'd1, 0);
    // Input reduction: 4095 - 3329 = 766.
    full_op("4095x1", 12'd4095, 12'd1, 12'd766, 0);
    full_op("0x4095", 12'd0, 12'd4095, 12'd0, 0);
    // Backpressure: 20000 mod 3329 = 26, held for 20 cycles.
    full_op("100x200", 12'd100, 12'd200, 12'd26, 20);

    // Reset on the 5th MUL edge aborts the operation.
    start_op(12'd1234, 12'd2345);
    in_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check("abort_ready", {31'd0, in_ready_o}, 32'd1);
    check("abort_valid", {31'd0, out_valid_o}, 32'd0);
    check("abort_res", {20'd0, res_o}, 32'd0);
    seen_valid = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (out_valid_o) seen_valid++;
    end
    check("abort_no_result", seen_valid, 32'd0);
    full_op("3x5", 12'd3, 12'd5, 12'd15, 0);

    // Random sweep against (a*b) mod Q with random output stalls.
    for (int n = 0; n < SWEEP_N; n++) begin
      ra = W'($urandom_range(0, 4095));
      rb = W'($urandom_range(0, 4095));
      exp_i = (int'(ra) * int'(rb)) % QM;
      start_op(ra, rb);
      wait_done(lat);
      check("sweep_latency", lat, 32'd12);
      check("sweep_res", {20'd0, res_o}, exp_i);
      finish_op(int'($urandom_range(0, 3)), W'(exp_i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
